// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and defaults for the alarm siren controller.
//   state_t    - FSM state encoding (also exported on state_o for debug)
//   *_DEF      - default parameter values
//   cnt_width  - width of the entry/siren countdown timer
package alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMED    = 3'd1,
    ENTRY    = 3'd2,
    SOUNDING = 3'd3,
    SILENCED = 3'd4
  } state_t;

  localparam int TICK_DIV_DEF    = 1000;
  localparam int ENTRY_DLY_DEF   = 30;
  localparam int SIREN_TIME_DEF  = 180;
  localparam int STROBE_HALF_DEF = 4;

  // Enough bits to hold the larger of the two timer reload values.
  function automatic int cnt_width(input int entry_dly, input int siren_time);
    int m;
    m = (entry_dly > siren_time) ? entry_dly : siren_time;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// alarm_tick_gen: timer-tick prescaler.
//   clk, rst - clock, async active-high reset
//   clr      - synchronous clear (restarts the tick period)
//   tick     - high for one cycle when the count reaches TICK_DIV-1
module alarm_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/alarm_siren_ctrl.sv
// alarm_siren_ctrl: annunciator stage behind Alarm_System.
//   clk, rst  - clock, async active-high reset
//   act_i     - armed flag (async, 2-flop synchronized)
//   alarm_i   - trip flag (async, 2-flop synchronized)
//   ack_i     - acknowledge/silence pulse (clk domain)
//   siren_o   - siren drive, bounded to SIREN_TIME ticks per sounding
//   strobe_o  - visual strobe, toggles every STROBE_HALF ticks
//   pending_o - entry delay in progress
//   latched_o - alarm memory, cleared by ack in DISARMED only
//   state_o   - FSM state encoding
// All outputs are registered from the next-state logic, so they line up
// with state_o and have no combinational path from the inputs.
module alarm_siren_ctrl
  import alarm_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int ENTRY_DLY   = ENTRY_DLY_DEF,
  parameter int SIREN_TIME  = SIREN_TIME_DEF,
  parameter int STROBE_HALF = STROBE_HALF_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       act_i,
  input  logic       alarm_i,
  input  logic       ack_i,
  output logic       siren_o,
  output logic       strobe_o,
  output logic       pending_o,
  output logic       latched_o,
  output logic [2:0] state_o
);

  localparam int TW = cnt_width(ENTRY_DLY, SIREN_TIME);
  localparam int SW = (STROBE_HALF > 1) ? $clog2(STROBE_HALF) : 1;

  logic          act_m, act_s, alm_m, alm_s, alm_q;
  state_t        state, nxt;
  logic [TW-1:0] tmr;
  logic [SW-1:0] scnt, scnt_n;
  logic          phase, phase_n;
  logic          tick, clr, expire, alm_rise, strobe_on;

  // Prescaler restarts on every transition so each state lasts a whole
  // number of tick periods.
  alarm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign alm_rise = alm_s & ~alm_q;
  // Tick that brings the countdown from 1 to 0.
  assign expire   = tick && (tmr <= TW'(1));
  assign clr      = (nxt != state);

  always_comb begin
    nxt = state;
    if (!act_s) nxt = DISARMED;       // disarm beats everything
    else begin
      case (state)
        DISARMED: nxt = ARMED;
        ARMED:    if (alm_s) nxt = (ENTRY_DLY == 0) ? SOUNDING : ENTRY;
        ENTRY:    if (expire) nxt = SOUNDING;
        SOUNDING: if (expire || ack_i) nxt = SILENCED;
        SILENCED: if (alm_rise) nxt = SOUNDING;
        default:  nxt = DISARMED;
      endcase
    end
  end

  // Strobe phase: restarts high on a fresh sounding, held across
  // SOUNDING<->SILENCED, forced low elsewhere.
  always_comb begin
    strobe_on = (nxt == SOUNDING) || (nxt == SILENCED);
    phase_n   = phase;
    scnt_n    = scnt;
    if (nxt == SOUNDING && (state == ARMED || state == ENTRY)) begin
      phase_n = 1'b1;
      scnt_n  = '0;
    end else if (!strobe_on) begin
      phase_n = 1'b0;
      scnt_n  = '0;
    end else if (tick) begin
      if (scnt == SW'(STROBE_HALF - 1)) begin
        phase_n = ~phase;
        scnt_n  = '0;
      end else begin
        scnt_n  = scnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_m     <= 1'b0;
      act_s     <= 1'b0;
      alm_m     <= 1'b0;
      alm_s     <= 1'b0;
      alm_q     <= 1'b0;
      state     <= DISARMED;
      tmr       <= '0;
      scnt      <= '0;
      phase     <= 1'b0;
      siren_o   <= 1'b0;
      strobe_o  <= 1'b0;
      pending_o <= 1'b0;
      latched_o <= 1'b0;
      state_o   <= 3'd0;
    end else begin
      act_m <= act_i;
      act_s <= act_m;
      alm_m <= alarm_i;
      alm_s <= alm_m;
      alm_q <= alm_s;

      state <= nxt;

      if (nxt == ENTRY && state != ENTRY)            tmr <= TW'(ENTRY_DLY);
      else if (nxt == SOUNDING && state != SOUNDING) tmr <= TW'(SIREN_TIME);
      else if (tick && tmr != '0)                    tmr <= tmr - 1'b1;

      scnt  <= scnt_n;
      phase <= phase_n;

      if (nxt == SOUNDING)                latched_o <= 1'b1;
      else if (state == DISARMED && ack_i) latched_o <= 1'b0;

      siren_o   <= (nxt == SOUNDING);
      pending_o <= (nxt == ENTRY);
      strobe_o  <= phase_n;
      state_o   <= nxt;
    end
  end

endmodule
